// File: rtl/pf_fetch_stage_pkg.sv
// Shared defaults and types for the phase-pipeline instruction-fetch stage.
package pf_fetch_stage_pkg;

   localparam int unsigned PF_PC_WIDTH    = 8;
   localparam int unsigned PF_INSTR_WIDTH = 32;
   localparam int unsigned PF_PC_STEP     = 4;
   localparam int unsigned PF_CNT_WIDTH   = 16;
   localparam logic [31:0] PF_NOP_INSTR   = 32'h0000_0000;

   // Number of low PC bits that must be zero for an aligned fetch address.
   function automatic int unsigned align_bits(input int unsigned step);
      return (step <= 1) ? 0 : $clog2(step);
   endfunction

   localparam int unsigned ALIGN_BITS = align_bits(PF_PC_STEP);

   // What the stage does at the coming edge, in priority order.
   typedef enum logic [1:0] {
      ActReset,
      ActBranch,
      ActStall,
      ActFetch
   } pf_action_e;

endpackage

// File: rtl/pf_fetch_stage_if.sv
// Fetch-stage bus: control in, ROM address/data, and the IF/ID register outputs.
interface pf_fetch_stage_if
   import pf_fetch_stage_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = PF_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = PF_INSTR_WIDTH,
   parameter int unsigned CNT_WIDTH   = PF_CNT_WIDTH
);

   logic                   LE;
   logic                   branch_taken;
   logic [PC_WIDTH-1:0]    branch_target;
   logic [INSTR_WIDTH-1:0] rom_data;
   logic [PC_WIDTH-1:0]    rom_addr;
   logic [INSTR_WIDTH-1:0] if_id_instr;
   logic [PC_WIDTH-1:0]    if_id_next_pc;
   logic                   if_id_valid;
   logic [CNT_WIDTH-1:0]   fetch_count;

   // The fetch stage is the master: it owns the PC and the IF/ID register.
   modport master (
      input  LE, branch_taken, branch_target, rom_data,
      output rom_addr, if_id_instr, if_id_next_pc, if_id_valid, fetch_count
   );

   modport slave (
      output LE, branch_taken, branch_target, rom_data,
      input  rom_addr, if_id_instr, if_id_next_pc, if_id_valid, fetch_count
   );

endinterface

// File: rtl/pf_pc_reg.sv
// Program counter register with synchronous clear, load enable and reset value.
module pf_pc_reg #(
   parameter int unsigned         WIDTH     = 8,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic [WIDTH-1:0] o_pc
);

   logic [WIDTH-1:0] r_pc;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_pc <= RESET_VAL;
      end else if (i_load) begin
         r_pc <= i_value;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/pf_fetch_stage.sv
// Instruction-fetch stage: PC, ROM addressing, IF/ID register and fetch counter.
module pf_fetch_stage
   import pf_fetch_stage_pkg::*;
#(
   parameter int unsigned            PC_WIDTH    = PF_PC_WIDTH,
   parameter int unsigned            INSTR_WIDTH = PF_INSTR_WIDTH,
   parameter int unsigned            PC_STEP     = PF_PC_STEP,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(PF_NOP_INSTR),
   parameter int unsigned            CNT_WIDTH   = PF_CNT_WIDTH
) (
   input  logic              Clk,
   input  logic              Clr,
   pf_fetch_stage_if.master  bus
);

   localparam int unsigned         AlignBits = align_bits(PC_STEP);
   localparam logic [PC_WIDTH-1:0] AlignMask = {PC_WIDTH{1'b1}} << AlignBits;
   localparam logic [PC_WIDTH-1:0] StepVal   = PC_WIDTH'(PC_STEP);

   logic [PC_WIDTH-1:0]    w_pc;
   logic [PC_WIDTH-1:0]    w_seq_pc;
   logic [PC_WIDTH-1:0]    w_pc_next;
   logic                   w_pc_load;
   pf_action_e             w_action;

   logic [INSTR_WIDTH-1:0] r_instr;
   logic [PC_WIDTH-1:0]    r_next_pc;
   logic                   r_valid;
   logic [CNT_WIDTH-1:0]   r_count;

   // Sequential PC wraps modulo 2^PC_WIDTH by truncation.
   assign w_seq_pc = w_pc + StepVal;

   always_comb begin
      w_action = ActFetch;
      if (Clr) begin
         w_action = ActReset;
      end else if (bus.branch_taken) begin
         w_action = ActBranch;
      end else if (!bus.LE) begin
         w_action = ActStall;
      end
   end

   always_comb begin
      w_pc_load = 1'b0;
      w_pc_next = w_seq_pc;
      unique case (w_action)
         ActBranch: begin
            w_pc_load = 1'b1;
            w_pc_next = bus.branch_target & AlignMask;
         end
         ActFetch: begin
            w_pc_load = 1'b1;
         end
         default: begin
            w_pc_load = 1'b0;
         end
      endcase
   end

   pf_pc_reg #(
      .WIDTH     (PC_WIDTH),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .Clk     (Clk),
      .Clr     (Clr),
      .i_load  (w_pc_load),
      .i_value (w_pc_next),
      .o_pc    (w_pc)
   );

   always_ff @(posedge Clk) begin
      unique case (w_action)
         ActReset: begin
            r_instr   <= NOP_INSTR;
            r_next_pc <= '0;
            r_valid   <= 1'b0;
            r_count   <= '0;
         end
         ActBranch: begin
            // Flush the wrong-path slot; next_pc and count are left alone.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end
         ActStall: begin
            r_valid <= r_valid;
         end
         ActFetch: begin
            r_instr   <= bus.rom_data;
            r_next_pc <= w_seq_pc;
            r_valid   <= 1'b1;
            if (r_count != {CNT_WIDTH{1'b1}}) begin
               r_count <= r_count + CNT_WIDTH'(1);
            end
         end
         default: begin
            r_valid <= r_valid;
         end
      endcase
   end

   assign bus.rom_addr      = w_pc;
   assign bus.if_id_instr   = r_instr;
   assign bus.if_id_next_pc = r_next_pc;
   assign bus.if_id_valid   = r_valid;
   assign bus.fetch_count   = r_count;

endmodule

// File: tb/tb_pf_fetch_stage.sv
// Directed bench for pf_fetch_stage; a second instance with a 2-bit counter checks saturation.
module tb_pf_fetch_stage;

   logic Clk;
   logic Clr;

   int unsigned n_checks;
   int unsigned n_errors;

   pf_fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(32), .CNT_WIDTH(16)) bus ();
   pf_fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

   pf_fetch_stage #(
      .PC_WIDTH    (8),
      .INSTR_WIDTH (32),
      .PC_STEP     (4),
      .RESET_PC    (8'h00),
      .NOP_INSTR   (32'h0000_0000),
      .CNT_WIDTH   (16)
   ) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   pf_fetch_stage #(
      .PC_WIDTH    (8),
      .INSTR_WIDTH (32),
      .PC_STEP     (4),
      .RESET_PC    (8'h00),
      .NOP_INSTR   (32'h0000_0000),
      .CNT_WIDTH   (2)
   ) dut_sat (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus2)
   );

   // ROM[i] = 0xE000_0000 + i, word-addressed by rom_addr >> 2.
   assign bus.rom_data  = 32'hE000_0000 + {26'd0, bus.rom_addr[7:2]};
   assign bus2.rom_data = 32'hE000_0000 + {26'd0, bus2.rom_addr[7:2]};

   assign bus2.LE            = bus.LE;
   assign bus2.branch_taken  = bus.branch_taken;
   assign bus2.branch_target = bus.branch_target;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic check_state(input string tag, input logic [7:0] addr, input logic [31:0] instr,
                              input logic [7:0] npc, input logic valid, input logic [15:0] cnt);
      check_eq({tag, ".addr"},  {24'd0, bus.rom_addr},      {24'd0, addr});
      check_eq({tag, ".instr"}, bus.if_id_instr,            instr);
      check_eq({tag, ".npc"},   {24'd0, bus.if_id_next_pc}, {24'd0, npc});
      check_eq({tag, ".valid"}, {31'd0, bus.if_id_valid},   {31'd0, valid});
      check_eq({tag, ".cnt"},   {16'd0, bus.fetch_count},   {16'd0, cnt});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Clr = 1'b1;
      bus.LE = 1'b1;
      bus.branch_taken = 1'b0;
      bus.branch_target = 8'h00;

      @(negedge Clk);
      step();
      check_state("reset", 8'h00, 32'h0, 8'h00, 1'b0, 16'd0);
      check_eq("reset.sat_cnt", {30'd0, bus2.fetch_count}, 32'd0);

      // Sequential fetch up to PC=0x08.
      Clr = 1'b0;
      step();
      check_state("seq0", 8'h04, 32'hE000_0000, 8'h04, 1'b1, 16'd1);
      step();
      check_state("seq1", 8'h08, 32'hE000_0001, 8'h08, 1'b1, 16'd2);

      // Three-edge stall: everything frozen.
      bus.LE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_state("stall", 8'h08, 32'hE000_0001, 8'h08, 1'b1, 16'd2);
      end

      // Resume with the instruction at 0x08.
      bus.LE = 1'b1;
      step();
      check_state("resume0", 8'h0C, 32'hE000_0002, 8'h0C, 1'b1, 16'd3);
      step();
      check_state("resume1", 8'h10, 32'hE000_0003, 8'h10, 1'b1, 16'd4);
      check_eq("sat.at4", {30'd0, bus2.fetch_count}, 32'd3);

      // Branch to 0x40 with flush, then the target instruction.
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'h40;
      step();
      check_state("br", 8'h40, 32'h0, 8'h10, 1'b0, 16'd4);
      bus.branch_taken = 1'b0;
      step();
      check_state("br_tgt", 8'h44, 32'hE000_0010, 8'h44, 1'b1, 16'd5);
      step();
      check_state("br_seq", 8'h48, 32'hE000_0011, 8'h48, 1'b1, 16'd6);

      // Misaligned branch during a stall: aligned to 0x44, bubble inserted.
      bus.LE = 1'b0;
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'h47;
      step();
      check_state("br_stall", 8'h44, 32'h0, 8'h48, 1'b0, 16'd6);
      bus.LE = 1'b1;
      bus.branch_taken = 1'b0;
      step();
      check_state("br_stall_tgt", 8'h48, 32'hE000_0011, 8'h48, 1'b1, 16'd7);

      // Branch to 0xFC, then PC wraps to 0x00.
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'hFC;
      step();
      check_state("wrap_br", 8'hFC, 32'h0, 8'h48, 1'b0, 16'd7);
      bus.branch_taken = 1'b0;
      step();
      check_state("wrap0", 8'h00, 32'hE000_003F, 8'h00, 1'b1, 16'd8);
      step();
      check_state("wrap1", 8'h04, 32'hE000_0000, 8'h04, 1'b1, 16'd9);
      check_eq("sat.at9", {30'd0, bus2.fetch_count}, 32'd3);

      // Clr wins over a concurrent branch and LE.
      Clr = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'h80;
      step();
      check_state("clr_prio", 8'h00, 32'h0, 8'h00, 1'b0, 16'd0);
      check_eq("clr_prio.sat_cnt", {30'd0, bus2.fetch_count}, 32'd0);
      Clr = 1'b0;
      bus.branch_taken = 1'b0;
      step();
      check_state("after_clr", 8'h04, 32'hE000_0000, 8'h04, 1'b1, 16'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
